// File: rtl/i2s_pkg.sv
// Shared types, widths and frame formatting for the I2S transmit framer.
package i2s_pkg;

  localparam int unsigned FRAME_W    = 64;
  localparam int unsigned SLOT_W     = 32;
  localparam int unsigned UNDERRUN_W = 16;
  localparam int unsigned BIT_W      = 6;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} i2s_state_t;

  // Left-justify each channel in its 32-bit slot; left channel occupies the upper slot.
  function automatic logic [FRAME_W-1:0] format_frame(input logic [SLOT_W-1:0] l,
                                                      input logic [SLOT_W-1:0] r,
                                                      input int unsigned       sample_w);
    logic [SLOT_W-1:0] l_slot;
    logic [SLOT_W-1:0] r_slot;
    l_slot = l << (SLOT_W - sample_w);
    r_slot = r << (SLOT_W - sample_w);
    return {l_slot, r_slot};
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry synchronous FIFO with registered full/empty flags.
module sample_fifo2 #(
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (empty) head <= wdata;
          else       tail <= wdata;
          full  <= !empty;
          empty <= 1'b0;
        end
        2'b01: begin
          head  <= tail;
          full  <= 1'b0;
          empty <= !full;
        end
        // Simultaneous push/pop only happens with one entry held, so the new pair becomes head.
        2'b11: head <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_framer.sv
// I2S bit/word clock generator and frame formatter feeding the 64-bit transmit shift register.
module i2s_tx_framer
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Enable,
  input  logic [SAMPLE_W-1:0]   L_Sample,
  input  logic [SAMPLE_W-1:0]   R_Sample,
  input  logic                  Sample_Valid,
  output logic                  Sample_Ready,
  output logic                  sclk,
  output logic                  lrclk,
  output logic [FRAME_W-1:0]    Din,
  output logic [UNDERRUN_W-1:0] Underrun_Count
);

  localparam int unsigned PAIR_W = 2 * SAMPLE_W;
  localparam int unsigned DIV_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  i2s_state_t        state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tick_c;
  logic              fall_c;
  logic              fetch_c;
  logic              push_c;
  logic              pop_c;
  logic              full_next_c;

  sample_fifo2 #(.WIDTH(PAIR_W)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push_c),
    .wdata ({L_Sample, R_Sample}),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick_c  = (div == DIV_W'(SCLK_HALF - 1));
  assign fall_c  = tick_c && sclk;
  assign fetch_c = ((state == IDLE) && Enable) ||
                   ((state == RUN) && fall_c && (bit_cnt == BIT_W'(31)));
  assign push_c  = Sample_Valid && Sample_Ready;
  assign pop_c   = fetch_c && !fifo_empty;

  // Ready is registered from the FIFO's next occupancy so it drops right after the filling push.
  assign full_next_c = fifo_full ? !pop_c : (push_c && !pop_c && !fifo_empty);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state          <= IDLE;
      div            <= '0;
      bit_cnt        <= '0;
      sclk           <= 1'b0;
      lrclk          <= 1'b0;
      Din            <= '0;
      Underrun_Count <= '0;
      Sample_Ready   <= 1'b0;
    end else begin
      Sample_Ready <= !full_next_c;

      if (fetch_c) begin
        if (!fifo_empty) begin
          Din <= format_frame(SLOT_W'(fifo_rdata[PAIR_W-1:SAMPLE_W]),
                              SLOT_W'(fifo_rdata[SAMPLE_W-1:0]), SAMPLE_W);
        end else begin
          Din <= '0;
          if (Underrun_Count != '1) Underrun_Count <= Underrun_Count + UNDERRUN_W'(1);
        end
      end

      case (state)
        IDLE: begin
          div     <= '0;
          bit_cnt <= '0;
          sclk    <= 1'b0;
          lrclk   <= 1'b0;
          if (Enable) state <= PRIME;
        end
        PRIME: begin
          div <= tick_c ? '0 : div + DIV_W'(1);
          if (tick_c) begin
            sclk <= !sclk;
            if (sclk) begin
              state   <= RUN;
              bit_cnt <= '0;
              lrclk   <= 1'b1;
            end
          end
        end
        RUN: begin
          div <= tick_c ? '0 : div + DIV_W'(1);
          if (tick_c) begin
            sclk <= !sclk;
            if (sclk) begin
              if (bit_cnt == BIT_W'(63)) begin
                // Enable is only honoured at the frame boundary.
                bit_cnt <= '0;
                if (Enable) begin
                  lrclk <= 1'b1;
                end else begin
                  state <= IDLE;
                  lrclk <= 1'b0;
                  div   <= '0;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                lrclk   <= (bit_cnt < BIT_W'(31));
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
